// File: rtl/body_rate_pid_pkg.sv
// Shared widths, state encoding, default gains and clamp constants for the
// body-rate PID controller.
package body_rate_pid_pkg;

  localparam int RATE_W = 16;
  localparam int OPS_W  = 32;

  // One-hot iteration sequence
  typedef enum logic [5:0] {
    ST_WAITING  = 6'b000001,
    ST_ERROR    = 6'b000010,
    ST_TERMS    = 6'b000100,
    ST_SUM      = 6'b001000,
    ST_LIMIT    = 6'b010000,
    ST_COMPLETE = 6'b100000
  } state_t;

  localparam int DEF_KP_MULT       = 4;
  localparam int DEF_KP_SHIFT      = 2;
  localparam int DEF_KI_MULT       = 1;
  localparam int DEF_KI_SHIFT      = 6;
  localparam int DEF_KD_MULT       = 2;
  localparam int DEF_KD_SHIFT      = 2;
  localparam int DEF_INT_LIMIT     = 32000;
  localparam int DEF_OUT_LIMIT     = 1600;
  localparam int DEF_THROTTLE_IDLE = 320;

endpackage

// File: rtl/pid_axis_math.sv
// Combinational per-axis PID arithmetic: P term, clamped integrator update,
// optional D term, I term, term sum and output clamp.
// Build option: BODY_RATE_PID_D_TERM_EN enables the derivative path.
module pid_axis_math
  import body_rate_pid_pkg::*;
#(
  parameter int KP_MULT   = DEF_KP_MULT,
  parameter int KP_SHIFT  = DEF_KP_SHIFT,
  parameter int KI_MULT   = DEF_KI_MULT,
  parameter int KI_SHIFT  = DEF_KI_SHIFT,
  parameter int KD_MULT   = DEF_KD_MULT,
  parameter int KD_SHIFT  = DEF_KD_SHIFT,
  parameter int INT_LIMIT = DEF_INT_LIMIT,
  parameter int OUT_LIMIT = DEF_OUT_LIMIT
) (
  input  logic signed [OPS_W-1:0]  err,
  input  logic signed [OPS_W-1:0]  acc,
`ifdef BODY_RATE_PID_D_TERM_EN
  input  logic signed [OPS_W-1:0]  prev_err,
  input  logic signed [OPS_W-1:0]  d_q,
  output logic signed [OPS_W-1:0]  d_term,
`endif
  input  logic signed [OPS_W-1:0]  acc_next_q,
  input  logic signed [OPS_W-1:0]  p_q,
  input  logic signed [OPS_W-1:0]  sum_q,
  output logic signed [OPS_W-1:0]  p_term,
  output logic signed [OPS_W-1:0]  acc_next,
  output logic signed [OPS_W-1:0]  sum,
  output logic signed [RATE_W-1:0] cmd
);

  // Inclusive symmetric clamp at operation width
  function automatic logic signed [OPS_W-1:0] sat_ops(input logic signed [OPS_W-1:0] v,
                                                      input logic signed [OPS_W-1:0] lim);
    if (v > lim)       return lim;
    else if (v < -lim) return -lim;
    else               return v;
  endfunction

  // Clamp then narrow to the command width; the limit always fits
  function automatic logic signed [RATE_W-1:0] sat_out(input logic signed [OPS_W-1:0] v,
                                                       input logic signed [OPS_W-1:0] lim);
    return RATE_W'(sat_ops(v, lim));
  endfunction

  logic signed [OPS_W-1:0] i_term;

  assign p_term   = (err * KP_MULT) >>> KP_SHIFT;
  assign acc_next = sat_ops(acc + err, INT_LIMIT);
  assign i_term   = (acc_next_q * KI_MULT) >>> KI_SHIFT;
`ifdef BODY_RATE_PID_D_TERM_EN
  assign d_term   = ((err - prev_err) * KD_MULT) >>> KD_SHIFT;
  assign sum      = p_q + i_term + d_q;
`else
  assign sum      = p_q + i_term;
`endif
  assign cmd      = sat_out(sum_q, OUT_LIMIT);

endmodule

// File: rtl/body_rate_pid.sv
// Inner-loop body-rate PID controller: one iteration per start pulse,
// three axes in parallel, saturated commands with active/complete handshake.
// Build option: BODY_RATE_PID_D_TERM_EN enables the derivative term.
module body_rate_pid
  import body_rate_pid_pkg::*;
#(
  parameter int KP_MULT       = DEF_KP_MULT,
  parameter int KP_SHIFT      = DEF_KP_SHIFT,
  parameter int KI_MULT       = DEF_KI_MULT,
  parameter int KI_SHIFT      = DEF_KI_SHIFT,
  parameter int KD_MULT       = DEF_KD_MULT,
  parameter int KD_SHIFT      = DEF_KD_SHIFT,
  parameter int INT_LIMIT     = DEF_INT_LIMIT,
  parameter int OUT_LIMIT     = DEF_OUT_LIMIT,
  parameter int THROTTLE_IDLE = DEF_THROTTLE_IDLE
) (
  input  logic                     us_clk,
  input  logic                     resetn,
  input  logic                     start_signal,
  input  logic signed [RATE_W-1:0] throttle_rate_in,
  input  logic signed [RATE_W-1:0] yaw_rate_target,
  input  logic signed [RATE_W-1:0] pitch_rate_target,
  input  logic signed [RATE_W-1:0] roll_rate_target,
  input  logic signed [RATE_W-1:0] yaw_rate_actual,
  input  logic signed [RATE_W-1:0] pitch_rate_actual,
  input  logic signed [RATE_W-1:0] roll_rate_actual,
  output logic signed [RATE_W-1:0] yaw_cmd,
  output logic signed [RATE_W-1:0] pitch_cmd,
  output logic signed [RATE_W-1:0] roll_cmd,
  output logic signed [RATE_W-1:0] throttle_out,
  output logic                     active_signal,
  output logic                     complete_signal
);

  localparam logic signed [RATE_W-1:0] IDLE_C = RATE_W'(THROTTLE_IDLE);

  state_t state_q, state_d;

  logic signed [RATE_W-1:0] tgt [3];
  logic signed [RATE_W-1:0] act [3];
  logic signed [RATE_W-1:0] throttle_lat;
  logic                     idle;

  logic signed [OPS_W-1:0]  err_p0      [3];
  logic signed [OPS_W-1:0]  acc         [3];
  logic signed [OPS_W-1:0]  p_p1        [3];
  logic signed [OPS_W-1:0]  acc_next_p1 [3];
  logic signed [OPS_W-1:0]  sum_p2      [3];
  logic signed [RATE_W-1:0] cmd_q       [3];

  logic signed [OPS_W-1:0]  p_w         [3];
  logic signed [OPS_W-1:0]  acc_next_w  [3];
  logic signed [OPS_W-1:0]  sum_w       [3];
  logic signed [RATE_W-1:0] cmd_w       [3];

`ifdef BODY_RATE_PID_D_TERM_EN
  logic signed [OPS_W-1:0]  prev_err    [3];
  logic signed [OPS_W-1:0]  prev_eff    [3];
  logic signed [OPS_W-1:0]  d_p1        [3];
  logic signed [OPS_W-1:0]  d_w         [3];
`endif

  assign tgt[0] = yaw_rate_target;
  assign tgt[1] = pitch_rate_target;
  assign tgt[2] = roll_rate_target;
  assign act[0] = yaw_rate_actual;
  assign act[1] = pitch_rate_actual;
  assign act[2] = roll_rate_actual;

  // Below idle throttle the iteration runs with cleared history
  assign idle = (throttle_lat < IDLE_C);

  for (genvar a = 0; a < 3; a++) begin : g_axis
`ifdef BODY_RATE_PID_D_TERM_EN
    assign prev_eff[a] = idle ? '0 : prev_err[a];
`endif
    pid_axis_math #(
      .KP_MULT(KP_MULT), .KP_SHIFT(KP_SHIFT),
      .KI_MULT(KI_MULT), .KI_SHIFT(KI_SHIFT),
      .KD_MULT(KD_MULT), .KD_SHIFT(KD_SHIFT),
      .INT_LIMIT(INT_LIMIT), .OUT_LIMIT(OUT_LIMIT)
    ) u_math (
      .err        (err_p0[a]),
      .acc        (acc[a]),
`ifdef BODY_RATE_PID_D_TERM_EN
      .prev_err   (prev_eff[a]),
      .d_q        (d_p1[a]),
      .d_term     (d_w[a]),
`endif
      .acc_next_q (acc_next_p1[a]),
      .p_q        (p_p1[a]),
      .sum_q      (sum_p2[a]),
      .p_term     (p_w[a]),
      .acc_next   (acc_next_w[a]),
      .sum        (sum_w[a]),
      .cmd        (cmd_w[a])
    );
  end

  // State register
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) state_q <= ST_WAITING;
    else         state_q <= state_d;
  end

  // Next-state: fixed sequence, gated only by start in WAITING
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAITING:  if (start_signal) state_d = ST_ERROR;
      ST_ERROR:    state_d = ST_TERMS;
      ST_TERMS:    state_d = ST_SUM;
      ST_SUM:      state_d = ST_LIMIT;
      ST_LIMIT:    state_d = ST_COMPLETE;
      ST_COMPLETE: state_d = ST_WAITING;
      default:     state_d = ST_WAITING;
    endcase
  end

  assign active_signal   = (state_q == ST_ERROR) || (state_q == ST_TERMS) ||
                           (state_q == ST_SUM)   || (state_q == ST_LIMIT);
  assign complete_signal = (state_q == ST_COMPLETE);

  // Datapath registers, each loaded in its own state
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      throttle_lat <= '0;
      throttle_out <= '0;
      for (int a = 0; a < 3; a++) begin
        err_p0[a]      <= '0;
        acc[a]         <= '0;
        p_p1[a]        <= '0;
        acc_next_p1[a] <= '0;
        sum_p2[a]      <= '0;
        cmd_q[a]       <= '0;
`ifdef BODY_RATE_PID_D_TERM_EN
        prev_err[a]    <= '0;
        d_p1[a]        <= '0;
`endif
      end
    end else begin
      case (state_q)
        // ERROR: latch throttle and form the 32-bit rate error
        ST_ERROR: begin
          throttle_lat <= throttle_rate_in;
          for (int a = 0; a < 3; a++)
            err_p0[a] <= {{(OPS_W-RATE_W){tgt[a][RATE_W-1]}}, tgt[a]} -
                         {{(OPS_W-RATE_W){act[a][RATE_W-1]}}, act[a]};
        end
        // TERMS: P, D and the clamped integrator candidate
        ST_TERMS: begin
          for (int a = 0; a < 3; a++) begin
            p_p1[a]        <= p_w[a];
            acc_next_p1[a] <= idle ? '0 : acc_next_w[a];
`ifdef BODY_RATE_PID_D_TERM_EN
            d_p1[a]        <= d_w[a];
`endif
          end
        end
        // SUM: commit history and add P + I + D
        ST_SUM: begin
          for (int a = 0; a < 3; a++) begin
            acc[a]      <= acc_next_p1[a];
            sum_p2[a]   <= sum_w[a];
`ifdef BODY_RATE_PID_D_TERM_EN
            prev_err[a] <= idle ? '0 : err_p0[a];
`endif
          end
        end
        // LIMIT: clamp and present commands with throttle
        ST_LIMIT: begin
          throttle_out <= throttle_lat;
          for (int a = 0; a < 3; a++) cmd_q[a] <= cmd_w[a];
        end
        default: ;
      endcase
    end
  end

  assign yaw_cmd   = cmd_q[0];
  assign pitch_cmd = cmd_q[1];
  assign roll_cmd  = cmd_q[2];

endmodule

// File: tb/tb_body_rate_pid.sv
// Scoreboard bench for body_rate_pid: directed iterations push expected
// commands; a monitor pops and compares on every complete pulse.
module tb_body_rate_pid;

`ifdef BODY_RATE_PID_D_TERM_EN
  localparam bit D_EN = 1'b1;
`else
  localparam bit D_EN = 1'b0;
`endif

  logic us_clk = 1'b0;
  logic resetn = 1'b0;
  logic start_signal = 1'b0;
  logic signed [15:0] throttle_rate_in = '0;
  logic signed [15:0] yaw_rate_target = '0, pitch_rate_target = '0, roll_rate_target = '0;
  logic signed [15:0] yaw_rate_actual = '0, pitch_rate_actual = '0, roll_rate_actual = '0;
  logic signed [15:0] yaw_cmd, pitch_cmd, roll_cmd, throttle_out;
  logic active_signal, complete_signal;

  body_rate_pid dut (
    .us_clk(us_clk), .resetn(resetn), .start_signal(start_signal),
    .throttle_rate_in(throttle_rate_in),
    .yaw_rate_target(yaw_rate_target), .pitch_rate_target(pitch_rate_target),
    .roll_rate_target(roll_rate_target),
    .yaw_rate_actual(yaw_rate_actual), .pitch_rate_actual(pitch_rate_actual),
    .roll_rate_actual(roll_rate_actual),
    .yaw_cmd(yaw_cmd), .pitch_cmd(pitch_cmd), .roll_cmd(roll_cmd),
    .throttle_out(throttle_out),
    .active_signal(active_signal), .complete_signal(complete_signal)
  );

  always #5 us_clk = ~us_clk;

  typedef struct { int y; int p; int r; int t; } exp_t;
  exp_t exp_q[$];
  exp_t cur;
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  task automatic expect_out(input int y, input int p, input int r, input int t);
    exp_t e;
    e.y = y; e.p = p; e.r = r; e.t = t;
    exp_q.push_back(e);
  endtask

  // Monitor: every complete pulse must match the oldest expectation
  always @(negedge us_clk) begin
    if (resetn && complete_signal) begin
      if (exp_q.size() == 0) check("unexpected_complete", 1, 0);
      else begin
        cur = exp_q.pop_front();
        check("yaw_cmd", yaw_cmd, cur.y);
        check("pitch_cmd", pitch_cmd, cur.p);
        check("roll_cmd", roll_cmd, cur.r);
        check("throttle_out", throttle_out, cur.t);
      end
    end
  end

  task automatic set_inputs(input int yt, input int ya, input int pt, input int pa,
                            input int rt, input int ra, input int thr);
    yaw_rate_target = 16'(yt);   yaw_rate_actual = 16'(ya);
    pitch_rate_target = 16'(pt); pitch_rate_actual = 16'(pa);
    roll_rate_target = 16'(rt);  roll_rate_actual = 16'(ra);
    throttle_rate_in = 16'(thr);
  endtask

  // One start pulse; returns cycles from start to complete
  task automatic run_iter(input int yt, input int ya, input int pt, input int pa,
                          input int rt, input int ra, input int thr, output int lat);
    @(negedge us_clk);
    set_inputs(yt, ya, pt, pa, rt, ra, thr);
    start_signal = 1'b1;
    lat = 0;
    do begin
      @(negedge us_clk);
      start_signal = 1'b0;
      lat++;
    end while (!complete_signal && lat < 20);
    if (!complete_signal) check("complete_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(negedge us_clk);
    resetn = 1'b0;
    repeat (2) @(negedge us_clk);
    resetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int n;
    int cyc;
    int acc;

    // Reset state
    repeat (3) @(negedge us_clk);
    check("rst_yaw", yaw_cmd, 0);
    check("rst_pitch", pitch_cmd, 0);
    check("rst_roll", roll_cmd, 0);
    check("rst_throttle", throttle_out, 0);
    check("rst_active", int'(active_signal), 0);
    check("rst_complete", int'(complete_signal), 0);
    resetn = 1'b1;

    // First iteration: P160 + I2 (+ D80)
    expect_out(0, D_EN ? 242 : 162, 0, 800);
    run_iter(0, 0, 160, 0, 0, 0, 800, lat);
    check("latency", lat, 5);

    // Second identical iteration: acc 320, I5, D0
    expect_out(0, 165, 0, 800);
    run_iter(0, 0, 160, 0, 0, 0, 800, lat);

    // Extreme error saturates both ways
    do_reset();
    expect_out(0, 0, 1600, 800);
    run_iter(0, 0, 0, 0, 32'h7FFF, 32'hFFFF8000, 800, lat);
    expect_out(0, 0, -1600, 800);
    run_iter(0, 0, 0, 0, 32'hFFFF8000, 32'h7FFF, 800, lat);

    // Start held high: 300 back-to-back iterations, integrator saturates
    do_reset();
    for (int k = 1; k <= 300; k++) begin
      acc = (160 * k > 32000) ? 32000 : 160 * k;
      expect_out(160 + acc / 64 + ((k == 1 && D_EN) ? 80 : 0), 0, 0, 800);
    end
    @(negedge us_clk);
    set_inputs(160, 0, 0, 0, 0, 0, 800);
    start_signal = 1'b1;
    n = 0;
    cyc = 0;
    while (n < 300 && cyc < 2500) begin
      @(negedge us_clk);
      cyc++;
      if (complete_signal) n++;
    end
    start_signal = 1'b0;
    check("b2b_count", n, 300);
    check("b2b_period", cyc, 1799);

    // Zero error at high throttle: I500, D -80
    expect_out(D_EN ? 420 : 500, 0, 0, 800);
    run_iter(0, 0, 0, 0, 0, 0, 800, lat);
    // Idle throttle clears the integrator
    expect_out(0, 0, 0, 100);
    run_iter(0, 0, 0, 0, 0, 0, 100, lat);
    // Fresh error after clearing sees only itself
    expect_out(D_EN ? 242 : 162, 0, 0, 800);
    run_iter(160, 0, 0, 0, 0, 0, 800, lat);

    // Reset in the middle of an iteration
    @(negedge us_clk);
    set_inputs(0, 0, 160, 0, 0, 0, 800);
    start_signal = 1'b1;
    @(negedge us_clk);
    start_signal = 1'b0;
    repeat (2) @(negedge us_clk);
    resetn = 1'b0;
    @(negedge us_clk);
    check("midrst_yaw", yaw_cmd, 0);
    check("midrst_throttle", throttle_out, 0);
    check("midrst_active", int'(active_signal), 0);
    check("midrst_complete", int'(complete_signal), 0);
    resetn = 1'b1;
    repeat (8) @(negedge us_clk);

    expect_out(0, D_EN ? 242 : 162, 0, 800);
    run_iter(0, 0, 160, 0, 0, 0, 800, lat);

    // Start during an active iteration is ignored
    expect_out(0, 165, 0, 800);
    @(negedge us_clk);
    set_inputs(0, 0, 160, 0, 0, 0, 800);
    start_signal = 1'b1;
    n = 0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge us_clk);
      start_signal = (c == 2);
      if (complete_signal) n++;
    end
    check("single_complete", n, 1);

    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
